// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        LEVEL_DONE = 3'd2,
        DEATH      = 3'd3,
        GAME_OVER  = 3'd4,
        WIN        = 3'd5
    } game_state_t;

    localparam int NUM_LEVELS_DEF = 8;
    localparam int SCORE_W        = 16;

    // Score increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game event inputs and status outputs exchanged between the game datapath
// (master) and the flow controller (slave).
interface game_flow_ctrl_if import game_pkg::*; ();

    logic                startOfFrame;
    logic                start_key;
    logic                bird_hit;
    logic                player_collision;
    logic                level_up;
    logic                levelResetN;
    logic                freeze;
    game_state_t         game_state;
    logic [2:0]          level_idx;
    logic [3:0]          lives;
    logic [SCORE_W-1:0]  score;

    modport master (
        output startOfFrame, start_key, bird_hit, player_collision,
        input  level_up, levelResetN, freeze, game_state, level_idx, lives, score
    );

    modport slave (
        input  startOfFrame, start_key, bird_hit, player_collision,
        output level_up, levelResetN, freeze, game_state, level_idx, lives, score
    );

endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame-based countdown: loads a frame count, decrements once per tick,
// holds at zero and flags done while zero.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Load has priority over a tick arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: start/play/pause/end FSM plus hit, lives, score
// and level bookkeeping. Pauses are timed by a shared frame timer.
module game_flow_ctrl import game_pkg::*; #(
    parameter int HITS_PER_LEVEL    = 4,
    parameter int NUM_LEVELS        = NUM_LEVELS_DEF,
    parameter int START_LIVES       = 3,
    parameter int TRANSITION_FRAMES = 120,
    parameter int DEATH_FRAMES      = 90
) (
    input logic             clk,
    input logic             resetN,
    game_flow_ctrl_if.slave bus
);

    localparam int MAX_FRAMES = (TRANSITION_FRAMES > DEATH_FRAMES) ? TRANSITION_FRAMES : DEATH_FRAMES;
    localparam int TW         = $clog2(MAX_FRAMES + 1);
    localparam int HW         = $clog2(HITS_PER_LEVEL + 1);

    game_state_t        state_reg, state_next;
    logic [2:0]         level_idx_reg, level_idx_next;
    logic [3:0]         lives_reg, lives_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [HW-1:0]      hits_reg, hits_next;
    logic               start_q_reg;
    logic               level_up_reg, level_up_next;
    logic               level_reset_n_reg, level_reset_n_next;

    logic               start_rise;
    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               timer_done;

    assign start_rise = bus.start_key & ~start_q_reg;

    frame_timer #(.W(TW)) u_frame_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (bus.startOfFrame),
        .done     (timer_done)
    );

    // State and counter registers; level_up/levelResetN are registered pulses.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg         <= IDLE;
            level_idx_reg     <= '0;
            lives_reg         <= 4'(START_LIVES);
            score_reg         <= '0;
            hits_reg          <= '0;
            start_q_reg       <= 1'b0;
            level_up_reg      <= 1'b0;
            level_reset_n_reg <= 1'b1;
        end else begin
            state_reg         <= state_next;
            level_idx_reg     <= level_idx_next;
            lives_reg         <= lives_next;
            score_reg         <= score_next;
            hits_reg          <= hits_next;
            start_q_reg       <= bus.start_key;
            level_up_reg      <= level_up_next;
            level_reset_n_reg <= level_reset_n_next;
        end
    end

    // Next-state and counter update logic; game events only act in PLAY.
    always_comb begin
        state_next         = state_reg;
        level_idx_next     = level_idx_reg;
        lives_next         = lives_reg;
        score_next         = score_reg;
        hits_next          = hits_reg;
        level_up_next      = 1'b0;
        level_reset_n_next = 1'b1;
        timer_load         = 1'b0;
        timer_val          = '0;

        case (state_reg)
            IDLE: begin
                if (start_rise) begin
                    state_next         = PLAY;
                    level_reset_n_next = 1'b0;
                    level_idx_next     = '0;
                    lives_next         = 4'(START_LIVES);
                    score_next         = '0;
                    hits_next          = '0;
                end
            end
            PLAY: begin
                // A collision in the same cycle as a hit wins; the hit is dropped.
                if (bus.player_collision) begin
                    lives_next = lives_reg - 4'd1;
                    if (lives_reg == 4'd1) begin
                        state_next = GAME_OVER;
                    end else begin
                        state_next = DEATH;
                        timer_load = 1'b1;
                        timer_val  = TW'(DEATH_FRAMES);
                    end
                end else if (bus.bird_hit) begin
                    score_next = score_sat_inc(score_reg);
                    hits_next  = hits_reg + HW'(1);
                    if (hits_reg == HW'(HITS_PER_LEVEL - 1)) begin
                        if (level_idx_reg == 3'(NUM_LEVELS - 1)) begin
                            state_next = WIN;
                        end else begin
                            state_next = LEVEL_DONE;
                            timer_load = 1'b1;
                            timer_val  = TW'(TRANSITION_FRAMES);
                        end
                    end
                end
            end
            LEVEL_DONE: begin
                if (timer_done) begin
                    state_next     = PLAY;
                    level_up_next  = 1'b1;
                    level_idx_next = level_idx_reg + 3'd1;
                    hits_next      = '0;
                end
            end
            DEATH: begin
                if (timer_done) begin
                    state_next = PLAY;
                end
            end
            GAME_OVER, WIN: begin
                if (start_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.level_up    = level_up_reg;
    assign bus.levelResetN = level_reset_n_reg;
    assign bus.freeze      = (state_reg != PLAY);
    assign bus.game_state  = state_reg;
    assign bus.level_idx   = level_idx_reg;
    assign bus.lives       = lives_reg;
    assign bus.score       = score_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios followed by
// random event traffic, all compared against an event-level game model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int HPL   = 2;
    localparam int NL    = 8;
    localparam int SL    = 3;
    localparam int TF    = 3;
    localparam int DF    = 2;

    logic clk;
    logic resetN;
    game_flow_ctrl_if bus();

    game_flow_ctrl #(
        .HITS_PER_LEVEL    (HPL),
        .NUM_LEVELS        (NL),
        .START_LIVES       (SL),
        .TRANSITION_FRAMES (TF),
        .DEATH_FRAMES      (DF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse-cycle counters observed on the falling edge.
    int lu_cnt = 0;
    int lr_cnt = 0;
    always @(negedge clk) begin
        if (bus.level_up === 1'b1) lu_cnt++;
        if (bus.levelResetN === 1'b0) lr_cnt++;
    end

    // Reference model: game rules expressed per event, no notion of cycles.
    game_state_t m_state;
    int m_level, m_lives, m_score, m_hits, m_pause, m_levelups, m_resets;

    function automatic void model_reset();
        m_state = IDLE; m_level = 0; m_lives = SL; m_score = 0; m_hits = 0; m_pause = 0;
    endfunction

    function automatic void model_start();
        if (m_state == IDLE) begin
            m_state = PLAY; m_level = 0; m_lives = SL; m_score = 0; m_hits = 0;
            m_resets++;
        end else if (m_state == GAME_OVER || m_state == WIN) begin
            m_state = IDLE;
        end
    endfunction

    function automatic void model_event(input bit h, input bit c, input bit s);
        if (m_state == PLAY) begin
            if (c) begin
                m_lives--;
                if (m_lives == 0) m_state = GAME_OVER;
                else begin m_state = DEATH; m_pause = DF; end
            end else if (h) begin
                if (m_score < 65535) m_score++;
                m_hits++;
                if (m_hits == HPL) begin
                    if (m_level == NL - 1) m_state = WIN;
                    else begin m_state = LEVEL_DONE; m_pause = TF; end
                end
            end
        end else if ((m_state == LEVEL_DONE || m_state == DEATH) && s) begin
            m_pause--;
            if (m_pause == 0) begin
                if (m_state == LEVEL_DONE) begin
                    m_level++; m_hits = 0; m_levelups++;
                end
                m_state = PLAY;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".state"},    32'(bus.game_state),     32'(m_state));
        chk({tag, ".freeze"},   32'(bus.freeze),         32'(m_state != PLAY));
        chk({tag, ".level"},    32'(bus.level_idx),      32'(m_level));
        chk({tag, ".lives"},    32'(bus.lives),          32'(m_lives));
        chk({tag, ".score"},    32'(bus.score),          32'(m_score));
        chk({tag, ".levelups"}, 32'(lu_cnt),             32'(m_levelups));
        chk({tag, ".lvlreset"}, 32'(lr_cnt),             32'(m_resets));
        $display("txn %s state=%0d level=%0d lives=%0d score=%0d", tag,
                 bus.game_state, bus.level_idx, bus.lives, bus.score);
    endtask

    // One-cycle event pulse followed by settling cycles.
    task automatic pulse(input bit h, input bit c, input bit s);
        @(negedge clk);
        bus.bird_hit = h; bus.player_collision = c; bus.startOfFrame = s;
        @(negedge clk);
        bus.bird_hit = 1'b0; bus.player_collision = 1'b0; bus.startOfFrame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_event(h, c, s);
    endtask

    task automatic press_start();
        @(negedge clk); bus.start_key = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.start_key = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_start();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        int r;
        bus.startOfFrame = 1'b0; bus.start_key = 1'b0;
        bus.bird_hit = 1'b0; bus.player_collision = 1'b0;
        m_levelups = 0; m_resets = 0;
        model_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check_all("reset");
        chk("reset.level_up", 32'(bus.level_up), 32'd0);
        chk("reset.levelResetN", 32'(bus.levelResetN), 32'd1);

        // 1: start game
        press_start();
        check_all("start");

        // 2: clear level 0
        pulse(1, 0, 0); check_all("hit1");
        pulse(1, 0, 0); check_all("hit2_level_done");
        frames(2);      check_all("transition_mid");
        frames(1);      check_all("transition_end");

        // 3: simultaneous hit+collision, hits preserved across death
        pulse(1, 0, 0); check_all("hit_l1");
        pulse(1, 1, 0); check_all("hit_and_collision");
        frames(DF);     check_all("death_end");
        pulse(1, 0, 0); check_all("hit_after_death");
        frames(TF);     check_all("level2");

        // 4: run out of lives
        pulse(0, 1, 0); frames(DF); check_all("second_death");
        pulse(0, 1, 0); check_all("game_over");
        pulse(1, 0, 0); check_all("hit_ignored");
        press_start();  check_all("back_to_idle");

        // 5: clear all levels
        press_start();
        base = lu_cnt;
        for (int lv = 0; lv < NL; lv++) begin
            pulse(1, 0, 0); pulse(1, 0, 0);
            if (lv < NL - 1) frames(TF);
        end
        check_all("win");
        chk("win.levelup_delta", 32'(lu_cnt - base), 32'd7);

        // 6: reset during a level transition
        press_start(); press_start();
        pulse(1, 0, 0); pulse(1, 0, 0); frames(1);
        check_all("pre_reset");
        @(negedge clk); resetN = 1'b0;
        @(negedge clk); resetN = 1'b1;
        model_reset();
        frames(TF + 2);
        check_all("after_midpause_reset");

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(99));
            if (r < 6)       press_start();
            else if (r < 40) pulse(1, 0, $urandom_range(1));
            else if (r < 48) pulse(0, 1, 0);
            else if (r < 52) pulse(1, 1, 0);
            else             pulse(0, 0, 1);
            check_all($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
